// File: rtl/pacman_soc_pio_arb_pkg.sv
// ---------------------------------------------------------------------------
// pacman_soc_pio_arb_pkg
// Shared types for the pacman_soc PIO arbiter:
//   - arb_state_e : arbiter FSM states (IDLE, ISSUE, CAPTURE)
//   - PIO_ADDR_W / PIO_DATA_W : default PIO address / data widths
//   - pio_cmd_t   : latched command at the default widths
//   - owner_onehot: turns a requester index into a one-hot response strobe
// ---------------------------------------------------------------------------
package pacman_soc_pio_arb_pkg;

    localparam int PIO_ADDR_W = 2;
    localparam int PIO_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic                  write;
        logic [PIO_ADDR_W-1:0] address;
        logic [PIO_DATA_W-1:0] writedata;
        logic                  owner;
    } pio_cmd_t;

    function automatic logic [1:0] owner_onehot(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/pacman_soc_rr_pick2.sv
// ---------------------------------------------------------------------------
// pacman_soc_rr_pick2
// Two-way round-robin pick, purely combinational.
//   valid[1:0]  in  : requesters asking for the shared slave
//   last_grant  in  : index of the requester granted most recently
//   grant[1:0]  out : one-hot grant (all zero when nobody asks)
// With a single requester it simply wins; on a tie the requester that was
// NOT granted last time wins, so neither side can starve the other.
// ---------------------------------------------------------------------------
module pacman_soc_rr_pick2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (valid[0] && (!valid[1] || last_grant)) begin
            grant = 2'b01;
        end else if (valid[1]) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/pacman_soc_pio_arbiter.sv
// ---------------------------------------------------------------------------
// pacman_soc_pio_arbiter
// Shares one Avalon-MM PIO slave between two requesters (Nios II bridge and
// the game-logic engine). Round-robin grant, one transaction in flight.
//
// Handshake: a command moves on a cycle where reqN_valid && reqN_ready.
// reqN_ready is combinational and only ever high in IDLE for the granted
// requester. The requester holds its command stable while valid && !ready;
// it may drop valid before ready without any effect. Each accepted command
// produces exactly one registered, one-cycle rspN_valid pulse to its owner
// (write: accept+2, read: accept+3); rspN_readdata carries read data (0 for
// writes) and is held until the next pulse to that requester.
//
// Ports
//   clk, reset_n                  clock, synchronous active-low reset
//   reqN_valid/write/address/writedata, reqN_ready   command channel, N=0,1
//   rspN_valid, rspN_readdata                         response channel, N=0,1
//   pio_address/chipselect/write_n/writedata          to the PIO slave
//   pio_readdata                                      from the PIO slave
//                                                     (registered, 1 cycle)
//   dbg_state                                         current FSM state
// ---------------------------------------------------------------------------
module pacman_soc_pio_arbiter
    import pacman_soc_pio_arb_pkg::*;
#(
    parameter int ADDR_W = PIO_ADDR_W,
    parameter int DATA_W = PIO_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_address,
    input  logic [DATA_W-1:0] req0_writedata,
    output logic              req0_ready,

    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_address,
    input  logic [DATA_W-1:0] req1_writedata,
    output logic              req1_ready,

    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_readdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_readdata,

    output logic [ADDR_W-1:0] pio_address,
    output logic              pio_chipselect,
    output logic              pio_write_n,
    output logic [DATA_W-1:0] pio_writedata,
    input  logic [DATA_W-1:0] pio_readdata,

    output arb_state_e        dbg_state
);

    // Command latch at this instance's widths.
    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] writedata;
        logic              owner;
    } cmd_t;

    arb_state_e        state_q, state_d;
    cmd_t              cmd_q, cmd_d;
    logic              last_grant_q, last_grant_d;
    logic [1:0]        rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp0_rd_q, rsp0_rd_d;
    logic [DATA_W-1:0] rsp1_rd_q, rsp1_rd_d;

    logic [1:0]        grant;
    logic [1:0]        ready_vec;
    logic [1:0]        rsp_strobe;

    pacman_soc_rr_pick2 u_pick (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    assign rsp_strobe = owner_onehot(cmd_q.owner);

    always_comb begin
        state_d        = state_q;
        cmd_d          = cmd_q;
        last_grant_d   = last_grant_q;
        rsp_valid_d    = 2'b00;
        rsp0_rd_d      = rsp0_rd_q;
        rsp1_rd_d      = rsp1_rd_q;
        ready_vec      = 2'b00;
        pio_chipselect = 1'b0;
        pio_write_n    = 1'b1;
        pio_address    = '0;
        pio_writedata  = '0;

        case (state_q)
            IDLE: begin
                ready_vec = grant;
                if (grant != 2'b00) begin
                    cmd_d.owner     = grant[1];
                    cmd_d.write     = grant[1] ? req1_write     : req0_write;
                    cmd_d.address   = grant[1] ? req1_address   : req0_address;
                    cmd_d.writedata = grant[1] ? req1_writedata : req0_writedata;
                    last_grant_d    = grant[1];
                    state_d         = ISSUE;
                end
            end

            ISSUE: begin
                pio_chipselect = 1'b1;
                pio_write_n    = ~cmd_q.write;
                pio_address    = cmd_q.address;
                pio_writedata  = cmd_q.writedata;
                if (cmd_q.write) begin
                    // Writes complete on the strobe itself; report zero data.
                    rsp_valid_d = rsp_strobe;
                    if (cmd_q.owner) rsp1_rd_d = '0;
                    else             rsp0_rd_d = '0;
                    state_d = IDLE;
                end else begin
                    state_d = CAPTURE;
                end
            end

            CAPTURE: begin
                // The PIO registered its read data during ISSUE; the bus is
                // already idle here and the data is taken from pio_readdata.
                rsp_valid_d = rsp_strobe;
                if (cmd_q.owner) rsp1_rd_d = pio_readdata;
                else             rsp0_rd_d = pio_readdata;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cmd_q        <= '0;
            last_grant_q <= 1'b1;
            rsp_valid_q  <= 2'b00;
            rsp0_rd_q    <= '0;
            rsp1_rd_q    <= '0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp0_rd_q    <= rsp0_rd_d;
            rsp1_rd_q    <= rsp1_rd_d;
        end
    end

    assign req0_ready    = ready_vec[0];
    assign req1_ready    = ready_vec[1];
    assign rsp0_valid    = rsp_valid_q[0];
    assign rsp1_valid    = rsp_valid_q[1];
    assign rsp0_readdata = rsp0_rd_q;
    assign rsp1_readdata = rsp1_rd_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_pacman_soc_pio_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pacman_soc_pio_arbiter
// Directed + randomized bench. A transaction-level reference model predicts,
// per cycle, ready, bus activity and response pulses/data from the timing
// rules (bus at accept+1, write rsp at accept+2, read rsp at accept+3) and the
// round-robin rule. A small PIO slave model answers the bus.
// ---------------------------------------------------------------------------
module tb_pacman_soc_pio_arbiter;
  import pacman_soc_pio_arb_pkg::*;

  localparam int MAXC = 2000;

  // clock / reset
  logic clk;
  logic reset_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT signals
  logic        req0_valid, req0_write, req0_ready;
  logic [1:0]  req0_address;
  logic [31:0] req0_writedata;
  logic        req1_valid, req1_write, req1_ready;
  logic [1:0]  req1_address;
  logic [31:0] req1_writedata;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_readdata, rsp1_readdata;
  logic [1:0]  pio_address;
  logic        pio_chipselect, pio_write_n;
  logic [31:0] pio_writedata, pio_readdata;
  arb_state_e  dbg_state;

  pacman_soc_pio_arbiter dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req0_valid     (req0_valid),
    .req0_write     (req0_write),
    .req0_address   (req0_address),
    .req0_writedata (req0_writedata),
    .req0_ready     (req0_ready),
    .req1_valid     (req1_valid),
    .req1_write     (req1_write),
    .req1_address   (req1_address),
    .req1_writedata (req1_writedata),
    .req1_ready     (req1_ready),
    .rsp0_valid     (rsp0_valid),
    .rsp0_readdata  (rsp0_readdata),
    .rsp1_valid     (rsp1_valid),
    .rsp1_readdata  (rsp1_readdata),
    .pio_address    (pio_address),
    .pio_chipselect (pio_chipselect),
    .pio_write_n    (pio_write_n),
    .pio_writedata  (pio_writedata),
    .pio_readdata   (pio_readdata),
    .dbg_state      (dbg_state)
  );

  // PIO slave: address 0 reads in_port / writes out_port, 1..3 are plain
  // registers. Read data is registered one cycle after the address.
  logic [31:0] in_port;
  logic [31:0] pio_out_port;
  logic [31:0] pio_regs [1:3];

  always @(posedge clk) begin
    if (!reset_n) begin
      pio_out_port <= '0;
      for (int i = 1; i <= 3; i++) pio_regs[i] <= '0;
      pio_readdata <= '0;
    end else begin
      pio_readdata <= (pio_address == 2'd0) ? in_port : pio_regs[pio_address];
      if (pio_chipselect && !pio_write_n) begin
        if (pio_address == 2'd0) pio_out_port <= pio_writedata;
        else                     pio_regs[pio_address] <= pio_writedata;
      end
    end
  end

  // reference model state
  int          cyc;
  int          free_at;
  bit          last_g;
  logic [31:0] m_regs [4];
  logic [31:0] exp_rd [2];
  bit          exp_cs [MAXC];
  bit          exp_wn [MAXC];
  logic [1:0]  exp_addr [MAXC];
  logic [31:0] exp_wd [MAXC];
  bit          exp_rv [2][MAXC];
  logic [31:0] exp_rdat [MAXC];
  bit          acc0, acc1;

  int n_assert;
  int n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=0x%08h expected=0x%08h", tag, cyc, obs, exp);
    end
  endtask

  task automatic finish_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  endtask

  task automatic clear_from(input int first);
    for (int k = first; k < MAXC; k++) begin
      exp_cs[k]    = 1'b0;
      exp_wn[k]    = 1'b1;
      exp_addr[k]  = '0;
      exp_wd[k]    = '0;
      exp_rv[0][k] = 1'b0;
      exp_rv[1][k] = 1'b0;
      exp_rdat[k]  = '0;
    end
  endtask

  // One clock cycle: check every output against the model at the negedge,
  // advance the model, then return just after the next posedge.
  task automatic step();
    int          want;
    bit          w;
    logic [1:0]  a;
    logic [31:0] d;
    @(negedge clk);
    if (cyc >= MAXC - 4) begin
      n_fail++;
      $display("FAIL cycle_budget cycle=%0d limit=%0d", cyc, MAXC - 4);
      finish_run();
    end
    want = -1;
    if (cyc >= free_at) begin
      if (req0_valid && req1_valid) want = last_g ? 0 : 1;
      else if (req0_valid)          want = 0;
      else if (req1_valid)          want = 1;
    end
    chk("req0_ready", 32'(req0_ready), 32'(want == 0));
    chk("req1_ready", 32'(req1_ready), 32'(want == 1));
    chk("pio_chipselect", 32'(pio_chipselect), 32'(exp_cs[cyc]));
    chk("pio_write_n", 32'(pio_write_n), 32'(exp_wn[cyc]));
    chk("pio_address", 32'(pio_address), 32'(exp_addr[cyc]));
    chk("pio_writedata", pio_writedata, exp_wd[cyc]);
    if (exp_rv[0][cyc]) exp_rd[0] = exp_rdat[cyc];
    if (exp_rv[1][cyc]) exp_rd[1] = exp_rdat[cyc];
    chk("rsp0_valid", 32'(rsp0_valid), 32'(exp_rv[0][cyc]));
    chk("rsp1_valid", 32'(rsp1_valid), 32'(exp_rv[1][cyc]));
    chk("rsp0_readdata", rsp0_readdata, exp_rd[0]);
    chk("rsp1_readdata", rsp1_readdata, exp_rd[1]);

    acc0 = 1'b0;
    acc1 = 1'b0;
    if (!reset_n) begin
      clear_from(cyc + 1);
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      free_at   = cyc + 1;
      last_g    = 1'b1;
      for (int i = 0; i < 4; i++) m_regs[i] = '0;
    end else if (want >= 0) begin
      w = (want == 1) ? req1_write : req0_write;
      a = (want == 1) ? req1_address : req0_address;
      d = (want == 1) ? req1_writedata : req0_writedata;
      exp_cs[cyc+1]   = 1'b1;
      exp_wn[cyc+1]   = ~w;
      exp_addr[cyc+1] = a;
      exp_wd[cyc+1]   = d;
      if (w) begin
        m_regs[a] = d;
        exp_rv[want][cyc+2] = 1'b1;
        exp_rdat[cyc+2]     = '0;
        free_at             = cyc + 2;
      end else begin
        exp_rv[want][cyc+3] = 1'b1;
        exp_rdat[cyc+3]     = (a == 2'd0) ? in_port : m_regs[a];
        free_at             = cyc + 3;
      end
      last_g = (want == 1);
      acc0   = (want == 0);
      acc1   = (want == 1);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // driver helpers
  task automatic drive0(input bit v, input bit w, input logic [1:0] a, input logic [31:0] d);
    req0_valid = v; req0_write = w; req0_address = a; req0_writedata = d;
  endtask

  task automatic drive1(input bit v, input bit w, input logic [1:0] a, input logic [31:0] d);
    req1_valid = v; req1_write = w; req1_address = a; req1_writedata = d;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int owners[$];
  int acc_cycles[$];
  int c0, c1, guard;
  int rsp0_seen;

  initial begin
    n_assert = 0;
    n_fail   = 0;
    cyc      = 0;
    free_at  = 0;
    last_g   = 1'b1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    clear_from(0);
    in_port = '0;
    drive0(0, 0, 2'd0, '0);
    drive1(0, 0, 2'd0, '0);

    // reset: two edges unchecked, then one checked cycle still in reset
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_dbg_state", 32'(dbg_state), 32'(IDLE));
    step();
    reset_n = 1'b1;
    idle_steps(2);

    // req0 write addr0 0xDEADBEEF
    drive0(1, 1, 2'd0, 32'hDEAD_BEEF);
    step();
    chk("wr0_accepted", 32'(acc0), 32'd1);
    drive0(0, 0, 2'd0, '0);
    idle_steps(3);
    chk("out_port_deadbeef", pio_out_port, 32'hDEAD_BEEF);

    // req1 read addr0 with in_port 0xA5
    in_port = 32'h0000_00A5;
    drive1(1, 0, 2'd0, '0);
    step();
    chk("rd1_accepted", 32'(acc1), 32'd1);
    drive1(0, 0, 2'd0, '0);
    idle_steps(4);
    chk("rd1_readdata_a5", rsp1_readdata, 32'h0000_00A5);

    // both valid continuously, 4 writes each
    c0 = 0; c1 = 0; guard = 0;
    drive0(1, 1, 2'd1, 32'h1000_0000);
    drive1(1, 1, 2'd2, 32'h2000_0000);
    while ((c0 < 4 || c1 < 4) && guard < 40) begin
      step();
      guard++;
      if (acc0) begin
        owners.push_back(0);
        c0++;
        if (c0 < 4) req0_writedata = 32'h1000_0000 + 32'(c0);
        else        req0_valid = 1'b0;
      end
      if (acc1) begin
        owners.push_back(1);
        c1++;
        if (c1 < 4) req1_writedata = 32'h2000_0000 + 32'(c1);
        else        req1_valid = 1'b0;
      end
    end
    chk("fair_count0", 32'(c0), 32'd4);
    chk("fair_count1", 32'(c1), 32'd4);
    chk("fair_first_owner", 32'(owners[0]), 32'd0);
    for (int i = 1; i < owners.size(); i++)
      chk("fair_alternate", 32'(owners[i]), 32'(1 - owners[i-1]));
    idle_steps(3);
    chk("fair_reg1", pio_regs[1], 32'h1000_0003);
    chk("fair_reg2", pio_regs[2], 32'h2000_0003);

    // req0 valid raised and dropped while req1 busy: nothing happens for req0
    rsp0_seen = 0;
    drive1(1, 0, 2'd3, '0);
    step();
    drive1(0, 0, 2'd0, '0);
    drive0(1, 1, 2'd1, 32'h0000_1234);
    step();
    drive0(0, 0, 2'd0, '0);
    for (int i = 0; i < 5; i++) begin
      step();
      if (rsp0_valid) rsp0_seen++;
    end
    chk("drop_no_rsp0", 32'(rsp0_seen), 32'd0);
    chk("drop_reg1_kept", pio_regs[1], 32'h1000_0003);

    // back-to-back reads from req0
    guard = 0;
    drive0(1, 0, 2'd2, '0);
    while (acc_cycles.size() < 3 && guard < 20) begin
      step();
      guard++;
      if (acc0) acc_cycles.push_back(cyc);
    end
    drive0(0, 0, 2'd0, '0);
    chk("b2b_accepts", 32'(acc_cycles.size()), 32'd3);
    for (int i = 1; i < acc_cycles.size(); i++)
      chk("b2b_spacing", 32'(acc_cycles[i] - acc_cycles[i-1]), 32'd3);
    idle_steps(4);
    chk("b2b_readdata", rsp0_readdata, 32'h2000_0003);

    // reset held 2 cycles in the middle of a read
    in_port = 32'h0000_005A;
    drive1(1, 0, 2'd0, '0);
    step();
    drive1(0, 0, 2'd0, '0);
    reset_n = 1'b0;
    step();
    step();
    chk("rst_dbg_state", 32'(dbg_state), 32'(IDLE));
    reset_n = 1'b1;
    idle_steps(4);
    chk("rst_rsp1_cleared", rsp1_readdata, 32'd0);

    // randomized traffic
    in_port = $urandom;
    for (int i = 0; i < 400; i++) begin
      if (acc0 || !req0_valid) begin
        if (acc0 || $urandom_range(0, 1) == 1)
          drive0($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), $urandom);
      end else if ($urandom_range(0, 7) == 0) begin
        req0_valid = 1'b0;
      end
      if (acc1 || !req1_valid) begin
        if (acc1 || $urandom_range(0, 1) == 1)
          drive1($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), $urandom);
      end else if ($urandom_range(0, 7) == 0) begin
        req1_valid = 1'b0;
      end
      step();
    end
    drive0(0, 0, 2'd0, '0);
    drive1(0, 0, 2'd0, '0);
    idle_steps(5);
    chk("rand_out_port", pio_out_port, m_regs[0]);
    for (int i = 1; i <= 3; i++) chk("rand_reg", pio_regs[i], m_regs[i]);

    finish_run();
  end

endmodule
